cfg_spi_master: RTL and testbench
=================================

# cfg_spi_master

Serial configuration transmitter that drives the 3-wire programming interface (SCLK, CS, SDI) of the configuration programmer from a parallel frame. It is the initiating end of the programming link. An on-chip controller or FPGA test harness loads a 72-bit frame, pulses `start`, and the block produces the exact CS/SCLK/SDI waveform the programmer expects: MSB first, sampled on SCLK rising edge, SCLK idle low, CS active low. It can optionally capture a readback stream on SDO.

## Interface
Parameters:
- `FRAME_BITS`, 72: bits per frame, MSB shifted first.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period, ≥1.
- `CS_SETUP`, 2: full SCLK periods with CS low before the first SCLK rise, ≥1.
- `CS_HOLD`, 2: full SCLK periods with CS low after the last SCLK fall, ≥1.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: request a frame. Sampled only while `busy`=0.
- `frame_data` in FRAME_BITS: frame to send. Latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at frame end.
- `SCLK` out 1: serial clock to the programmer.
- `CS` out 1: chip select, active low.
- `SDI` out 1: serial data to the programmer.
- `SDO` in 1: readback data. Present only with `SPI_READBACK_EN`.
- `rx_data` out FRAME_BITS: captured readback. Present only with `SPI_READBACK_EN`.

## Operation
- All outputs are registered.
- Reset values: `CS`=1, `SCLK`=0, `SDI`=0, `busy`=0, `done`=0, `rx_data`=0.
- Shift register `sr` holds the latched frame. A bit counter runs 0..FRAME_BITS-1. A half-period counter runs 0..CLK_DIV-1.
- States and transitions:
  - IDLE: `CS`=1, `SCLK`=0, `SDI`=0. On `start`=1, latch `frame_data` into `sr` and go to SETUP.
  - SETUP: `CS`=0, `SCLK`=0, `SDI`=`sr[MSB]`. Stay 2·CLK_DIV·CS_SETUP cycles, then go to SHIFT.
  - SHIFT: each bit is one low half followed by one high half.
    - `SCLK` rises after the low half and falls after the high half.
    - On each falling edge (the same `clk` edge), shift `sr` left and drive `SDI` with the new MSB. `SDI` is therefore stable for the whole period around the rising edge.
    - After the falling edge of bit FRAME_BITS-1, go to HOLD. `SDI` is driven to 0 on that edge.
  - HOLD: `CS`=0, `SCLK`=0, `SDI`=0. Stay 2·CLK_DIV·CS_HOLD cycles, then drive `CS`=1, pulse `done`, clear `busy`, and return to IDLE.
- `start` while `busy`=1 is ignored and not queued. Changes to `frame_data` after acceptance have no effect.
- `reset` asserted mid-frame: all outputs return to reset values on the next `clk` edge. The frame is abandoned, no `done` pulse is issued, and CS rises immediately.
- Exactly FRAME_BITS SCLK rising edges occur per frame. SCLK never toggles while CS is high.

## Timing
- `start` sampled at edge N: `CS`=0 and `busy`=1 at N+1.
- First SCLK rise: N+1+2·CLK_DIV·CS_SETUP+CLK_DIV.
- CS-low duration: 2·CLK_DIV·(CS_SETUP+FRAME_BITS+CS_HOLD) cycles. With defaults this is 608 cycles.
- `done`=1 for exactly one cycle, in the same cycle that `CS` returns to 1 and `busy` returns to 0.
- A new `start` is accepted in the cycle after `done`, giving a minimum CS-high gap of 1 cycle.
- SCLK frequency is f_clk/(2·CLK_DIV).

## Configuration
- `SPI_READBACK_EN` defined:
  - The `SDO` and `rx_data` ports exist.
  - `SDO` is sampled on the `clk` edge that raises SCLK and shifted into `rx_data` LSB-first-in, so the first sampled bit ends up as the MSB.
  - `rx_data` is updated only during SHIFT and holds its value from `done` until the next accepted `start`, when it is cleared to 0.
- `SPI_READBACK_EN` undefined:
  - No `SDO` or `rx_data` ports and no capture logic.
  - Transmit behaviour is identical in both builds.

## Test plan
- Reset then idle: hold `reset`=0 for 3 cycles, release, wait 50 cycles → `CS`=1, `SCLK`=0, `SDI`=0, `busy`=0, `done` never asserted.
- Nominal frame:
  - Stimulus: `frame_data`=72'h02DEECED58A8C8686E, pulse `start`.
  - Required: 72 SCLK rises, bits sampled at each rise equal to the frame MSB first, and CS low for exactly 608 cycles.
  - Required: the programmer instance under test decodes the same 9 bytes, 2,222,236,237,88,168,200,104,110.
- Start while busy: pulse `start` with a second pattern 100 cycles into a frame → only the first frame is transmitted, and exactly one `done` pulse occurs.
- Reset mid-frame: assert `reset` at SCLK rise 30 → `CS`=1 and `SCLK`=0 on the next edge, no `done` pulse; a following frame of 72'hFFFF_FFFF_FFFF_FFFF_FF is transmitted correctly.
- Back-to-back frames with CLK_DIV=1:
  - Stimulus: assert `start` in the cycle after `done`.
  - Required: CS high for exactly 1 cycle and SCLK at f_clk/2.
  - Required: both frames, 72'h0 and 72'h800000000000000001, are received bit-exact.
- Readback (`SPI_READBACK_EN` defined): loop `SDI` back to `SDO` → `rx_data` equals `frame_data` at `done`.

Source files
------------

// File: rtl/cfg_spi_master_if.sv
// ----------------------------------------------------------------------------
// cfg_spi_master_if
// Groups the host handshake and the 3-wire programming link of cfg_spi_master.
//
// Signals:
//   start       host -> master   request a frame (sampled while busy=0)
//   frame_data  host -> master   FRAME_BITS frame, MSB shifted first
//   busy        master -> host   frame in progress
//   done        master -> host   one-cycle end-of-frame pulse
//   SCLK        master -> prog   serial clock, idle low
//   CS          master -> prog   chip select, active low
//   SDI         master -> prog   serial data, stable around SCLK rise
//   SDO         prog -> master   readback data     (SPI_READBACK_EN only)
//   rx_data     master -> host   captured readback (SPI_READBACK_EN only)
//
// Optional feature macro: SPI_READBACK_EN
// ----------------------------------------------------------------------------
interface cfg_spi_master_if #(
    parameter int unsigned FRAME_BITS = 72
);
    logic                  start;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  busy;
    logic                  done;
    logic                  SCLK;
    logic                  CS;
    logic                  SDI;
`ifdef SPI_READBACK_EN
    logic                  SDO;
    logic [FRAME_BITS-1:0] rx_data;
`endif

    modport master (
        input  start,
        input  frame_data,
        output busy,
        output done,
        output SCLK,
        output CS,
        output SDI
`ifdef SPI_READBACK_EN
        ,
        input  SDO,
        output rx_data
`endif
    );

    modport slave (
        output start,
        output frame_data,
        input  busy,
        input  done,
        input  SCLK,
        input  CS,
        input  SDI
`ifdef SPI_READBACK_EN
        ,
        output SDO,
        input  rx_data
`endif
    );
endinterface

// File: rtl/cfg_spi_master.sv
// ----------------------------------------------------------------------------
// cfg_spi_master
// Serial configuration transmitter: shifts a parallel frame out on the
// programmer's CS/SCLK/SDI wires, MSB first, data sampled by the programmer on
// SCLK rise, SCLK idle low, CS active low. All outputs are registered.
//
// Ports:
//   clk    system clock (single domain)
//   reset  synchronous, active-low reset
//   bus    cfg_spi_master_if.master: start/frame_data/busy/done handshake and
//          SCLK/CS/SDI (+ SDO/rx_data) serial link
//
// Parameters:
//   FRAME_BITS  bits per frame (>=2)
//   CLK_DIV     clk cycles per SCLK half-period (>=1)
//   CS_SETUP    SCLK periods of CS low before the first SCLK rise (>=1)
//   CS_HOLD     SCLK periods of CS low after the last SCLK fall (>=1)
//
// Optional feature macro: SPI_READBACK_EN (capture SDO into rx_data on each
// SCLK-raising clk edge, first bit ends up as MSB).
// ----------------------------------------------------------------------------
module cfg_spi_master #(
    parameter int unsigned FRAME_BITS = 72,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic             clk,
    input  logic             reset,
    cfg_spi_master_if.master bus
);
    localparam int unsigned SETUP_CYC = 2 * CLK_DIV * CS_SETUP;
    localparam int unsigned HOLD_CYC  = 2 * CLK_DIV * CS_HOLD;
    localparam int unsigned WAIT_MAX  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned WW        = $clog2(WAIT_MAX);
    localparam int unsigned BW        = $clog2(FRAME_BITS);
    localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DW-1:0]         div_q, div_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  sdi_q, sdi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef SPI_READBACK_EN
    logic [FRAME_BITS-1:0] rx_q, rx_d;
`endif

    logic half_end;
    logic setup_end;
    logic hold_end;
    logic last_bit;

    assign half_end  = (div_q == DW'(CLK_DIV - 1));
    assign setup_end = (wait_q == WW'(SETUP_CYC - 1));
    assign hold_end  = (wait_q == WW'(HOLD_CYC - 1));
    assign last_bit  = (bit_q == BW'(FRAME_BITS - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            wait_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_READBACK_EN
            rx_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            wait_q  <= wait_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_READBACK_EN
            rx_q    <= rx_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (setup_end) state_d = SHIFT;
            SHIFT:   if (half_end && sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (hold_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        sr_d   = sr_q;
        bit_d  = bit_q;
        div_d  = div_q;
        wait_d = wait_q;
        cs_d   = cs_q;
        sclk_d = sclk_q;
        sdi_d  = sdi_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef SPI_READBACK_EN
        rx_d   = rx_q;
`endif
        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                sdi_d  = 1'b0;
                busy_d = 1'b0;
                wait_d = '0;
                if (bus.start) begin
                    sr_d   = bus.frame_data;
                    cs_d   = 1'b0;
                    sdi_d  = bus.frame_data[FRAME_BITS-1];
                    busy_d = 1'b1;
`ifdef SPI_READBACK_EN
                    rx_d   = '0;
`endif
                end
            end
            SETUP: begin
                bit_d  = '0;
                div_d  = '0;
                wait_d = setup_end ? '0 : wait_q + WW'(1);
            end
            SHIFT: begin
                div_d = half_end ? '0 : div_q + DW'(1);
                if (half_end) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
`ifdef SPI_READBACK_EN
                        rx_d   = {rx_q[FRAME_BITS-2:0], bus.SDO};
`endif
                    end else begin
                        // Falling edge: SDI moves to the next bit on the same
                        // clk edge, so it is stable across the next rise.
                        sclk_d = 1'b0;
                        sr_d   = sr_q << 1;
                        if (last_bit) begin
                            sdi_d  = 1'b0;
                            bit_d  = '0;
                            wait_d = '0;
                        end else begin
                            sdi_d = sr_q[FRAME_BITS-2];
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                wait_d = hold_end ? '0 : wait_q + WW'(1);
                if (hold_end) begin
                    cs_d   = 1'b1;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.CS   = cs_q;
    assign bus.SCLK = sclk_q;
    assign bus.SDI  = sdi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SPI_READBACK_EN
    assign bus.rx_data = rx_q;
`endif

endmodule

// File: tb/tb_cfg_spi_master.sv
`timescale 1ns/1ps
module tb_cfg_spi_master;
    localparam int unsigned FB = 72;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cfg_spi_master_if #(.FRAME_BITS(FB)) bus0 ();
    cfg_spi_master_if #(.FRAME_BITS(FB)) bus1 ();

    cfg_spi_master #(.FRAME_BITS(FB), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    cfg_spi_master #(.FRAME_BITS(FB), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

`ifdef SPI_READBACK_EN
    assign bus0.SDO = bus0.SDI;
    assign bus1.SDO = bus1.SDI;
`endif

    typedef struct {
        int          d;
        logic [FB-1:0] f;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Hand-computed per-instance expectations: CS low cycles, cs_low count at
    // first rise, clk cycles between rises.
    int EXP_LOW[2] = '{608, 152};
    int EXP_FR[2]  = '{21, 6};
    int PER[2]     = '{8, 2};

    int            cs_low[2]     = '{0, 0};
    int            rises[2]      = '{0, 0};
    int            since[2]      = '{0, 0};
    int            first_rise[2] = '{0, 0};
    int            gap[2]        = '{0, 0};
    int            last_gap[2]   = '{0, 0};
    int            done_cnt[2]   = '{0, 0};
    int            exp_done[2]   = '{0, 0};
    bit            bad_per[2]    = '{1'b0, 1'b0};
    bit            sclk_hi_cs[2] = '{1'b0, 1'b0};
    bit            prev_cs[2]    = '{1'b1, 1'b1};
    bit            prev_sclk[2]  = '{1'b0, 1'b0};
    logic [FB-1:0] cap[2];
    logic [FB-1:0] last_rx[2];

    int unsigned exp_bytes[9] = '{2, 222, 236, 237, 88, 168, 200, 104, 110};

    task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Programmer-side model: samples SDI on SCLK rises, times CS, and scores
    // each done pulse against the oldest queued expectation.
    task automatic mon_step(input int d, input logic cs, input logic sclk,
                            input logic sdi, input logic dn, input logic bsy);
        exp_t e;
        logic [FB-1:0] rxa;
        if (cs && sclk) sclk_hi_cs[d] = 1'b1;
        if (cs) begin
            if (!prev_cs[d]) gap[d] = 0;
            gap[d]++;
        end else begin
            if (prev_cs[d]) begin
                last_gap[d]   = gap[d];
                cs_low[d]     = 0;
                rises[d]      = 0;
                cap[d]        = '0;
                bad_per[d]    = 1'b0;
                first_rise[d] = 0;
                since[d]      = 0;
            end
            cs_low[d]++;
            since[d]++;
            if (sclk && !prev_sclk[d]) begin
                if (rises[d] == 0) first_rise[d] = cs_low[d];
                else if (since[d] != PER[d]) bad_per[d] = 1'b1;
                since[d] = 0;
                rises[d]++;
                cap[d] = {cap[d][FB-2:0], sdi};
            end
        end
        if (dn) begin
            done_cnt[d]++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_unexpected_done: got done expected none", d);
            end else begin
                e = sb.pop_front();
                last_rx[d] = cap[d];
                chk($sformatf("dut%0d_owner", d), FB'(d), FB'(e.d));
                chk($sformatf("dut%0d_frame", d), cap[d], e.f);
                chk($sformatf("dut%0d_rises", d), FB'(rises[d]), FB'(72));
                chk($sformatf("dut%0d_cs_low", d), FB'(cs_low[d]), FB'(EXP_LOW[d]));
                chk($sformatf("dut%0d_first_rise", d), FB'(first_rise[d]), FB'(EXP_FR[d]));
                chk($sformatf("dut%0d_sclk_period_bad", d), FB'(bad_per[d]), FB'(0));
                chk($sformatf("dut%0d_sclk_while_cs_high", d), FB'(sclk_hi_cs[d]), FB'(0));
                chk($sformatf("dut%0d_cs_at_done", d), FB'(cs), FB'(1));
                chk($sformatf("dut%0d_busy_at_done", d), FB'(bsy), FB'(0));
`ifdef SPI_READBACK_EN
                rxa = (d == 0) ? bus0.rx_data : bus1.rx_data;
                chk($sformatf("dut%0d_rx_data", d), rxa, e.f);
`else
                rxa = '0;
`endif
            end
        end
        prev_cs[d]   = cs;
        prev_sclk[d] = sclk;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, bus0.CS, bus0.SCLK, bus0.SDI, bus0.done, bus0.busy);
            mon_step(1, bus1.CS, bus1.SCLK, bus1.SDI, bus1.done, bus1.busy);
        end
    end

    task automatic send(input int d, input logic [FB-1:0] f, input bit expect_done);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin bus0.start = 1'b1; bus0.frame_data = f; end
        else        begin bus1.start = 1'b1; bus1.frame_data = f; end
        if (expect_done) begin
            e.d = d;
            e.f = f;
            sb.push_back(e);
            exp_done[d]++;
        end
        @(negedge clk);
        // Frame changes after acceptance must not reach the wire
        if (d == 0) begin bus0.start = 1'b0; bus0.frame_data = ~f; end
        else        begin bus1.start = 1'b0; bus1.frame_data = ~f; end
        chk($sformatf("dut%0d_busy_after_start", d), FB'((d == 0) ? bus0.busy : bus1.busy), FB'(1));
        chk($sformatf("dut%0d_cs_after_start", d), FB'((d == 0) ? bus0.CS : bus1.CS), FB'(0));
`ifdef SPI_READBACK_EN
        chk($sformatf("dut%0d_rx_cleared", d), (d == 0) ? bus0.rx_data : bus1.rx_data, '0);
`endif
    endtask

    task automatic wait_done(input int d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt[d] >= exp_done[d]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d_done_timeout: got %0d done pulses expected %0d", d, done_cnt[d], exp_done[d]);
        end
        @(negedge clk);
    endtask

    initial begin
        bit found;
        exp_t e;
        bus0.start = 1'b0; bus0.frame_data = '0;
        bus1.start = 1'b0; bus1.frame_data = '0;

        // Reset then idle
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_cs",   FB'(bus0.CS),   FB'(1));
        chk("idle_sclk", FB'(bus0.SCLK), FB'(0));
        chk("idle_sdi",  FB'(bus0.SDI),  FB'(0));
        chk("idle_busy", FB'(bus0.busy), FB'(0));
        chk("idle_cs1",  FB'(bus1.CS),   FB'(1));
        chk("idle_done_count", FB'(done_cnt[0] + done_cnt[1]), FB'(0));

        // Nominal frame and byte decode
        send(0, 72'h02DEECED58A8C8686E, 1'b1);
        wait_done(0, 2000);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("nominal_byte%0d", i), FB'(last_rx[0][71-8*i -: 8]), FB'(exp_bytes[i]));
        end

        // Start while busy is ignored
        send(0, 72'h123456789ABCDEF012, 1'b1);
        repeat (100) @(negedge clk);
        bus0.start = 1'b1;
        bus0.frame_data = 72'hC3C3C3C3C3C3C3C3C3;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0, 2000);
        repeat (700) @(negedge clk);
        chk("busy_start_done_count", FB'(done_cnt[0]), FB'(exp_done[0]));
        chk("busy_start_queue_empty", FB'(sb.size()), FB'(0));

        // Reset mid-frame at SCLK rise 30
        send(0, 72'hA5A5A5A5A5A5A5A5A5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (rises[0] >= 30) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rise30_timeout: got %0d rises expected 30", rises[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cs",   FB'(bus0.CS),   FB'(1));
        chk("abort_sclk", FB'(bus0.SCLK), FB'(0));
        chk("abort_sdi",  FB'(bus0.SDI),  FB'(0));
        chk("abort_busy", FB'(bus0.busy), FB'(0));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", FB'(done_cnt[0]), FB'(exp_done[0]));
        send(0, 72'hFFFFFFFFFFFFFFFFFF, 1'b1);
        wait_done(0, 2000);

        // Back-to-back frames with CLK_DIV=1
        send(1, 72'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus1.done) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_first_done_timeout: got no done expected done");
        end else begin
            bus1.start      = 1'b1;
            bus1.frame_data = 72'h800000000000000001;
            e.d = 1;
            e.f = 72'h800000000000000001;
            sb.push_back(e);
            exp_done[1]++;
            @(negedge clk);
            bus1.start      = 1'b0;
            bus1.frame_data = '0;
        end
        wait_done(1, 1000);
        chk("b2b_cs_high_gap", FB'(last_gap[1]), FB'(1));

        repeat (20) @(negedge clk);
        chk("final_queue_empty", FB'(sb.size()), FB'(0));
        chk("final_done0", FB'(done_cnt[0]), FB'(exp_done[0]));
        chk("final_done1", FB'(done_cnt[1]), FB'(exp_done[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
